// File: rtl/qcl_accum_sequencer.sv
// rtl/qcl_accum_sequencer.sv - frames triggered records into accumulation passes for the waveform RAM accumulator
module qcl_accum_sequencer #(
    parameter int els_p        = 1024,
    parameter int width_p      = 14,
    parameter int pass_width_p = 16,
    parameter int drain_p      = 3
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      cfg_v_i,
    input  logic [$clog2(els_p):0]    cfg_samples_i,
    input  logic [pass_width_p-1:0]   cfg_passes_i,
    output logic                      cfg_err_o,
    input  logic                      trig_i,
    input  logic                      sample_v_i,
    input  logic [width_p-1:0]        data_i,
    output logic                      acc_enable_o,
    output logic                      acc_clear_o,
    output logic [$clog2(els_p)-1:0]  acc_addr_o,
    output logic [width_p-1:0]        acc_data_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [pass_width_p-1:0]   pass_cnt_o,
    output logic                      trig_miss_o
);

    localparam int addr_w_lp  = $clog2(els_p);
    localparam int drain_w_lp = $clog2(drain_p + 2);
    localparam logic [addr_w_lp:0]    els_lp       = (addr_w_lp + 1)'(els_p);
    localparam logic [drain_w_lp-1:0] drain_last_lp = drain_w_lp'(drain_p + 1);

    typedef enum logic [2:0] {
        idle_s, armed_s, run_s, drain_s, done_s
    } state_e;

    state_e                  state_r, state_n;
    logic [addr_w_lp:0]      n_r;
    logic [pass_width_p-1:0] p_r;
    logic [addr_w_lp-1:0]    k_r;
    logic [drain_w_lp-1:0]   drain_cnt_r;

    logic                    cfg_open, cfg_ok, cfg_load;
    logic                    accept, last_sample, drain_end, trig_late;
    logic [pass_width_p-1:0] pass_next;

    assign cfg_open    = (state_r == idle_s) || (state_r == done_s);
    assign cfg_ok      = (cfg_samples_i != '0) && (cfg_samples_i <= els_lp) && (cfg_passes_i != '0);
    assign cfg_load    = cfg_v_i && cfg_open && cfg_ok;
    assign accept      = (state_r == run_s) && sample_v_i;
    assign last_sample = accept && ({1'b0, k_r} == (n_r - 1'b1));
    assign drain_end   = (state_r == drain_s) && (drain_cnt_r == drain_last_lp);
    assign trig_late   = trig_i && ((state_r == run_s) || (state_r == drain_s));
    assign pass_next   = pass_cnt_o + 1'b1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= idle_s;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            idle_s, done_s: if (cfg_load) state_n = armed_s;
            armed_s:        if (trig_i) state_n = run_s;
            run_s:          if (last_sample) state_n = drain_s;
            drain_s:        if (drain_end) state_n = (pass_next == p_r) ? done_s : armed_s;
            default:        state_n = idle_s;
        endcase
    end

    always_comb begin
        busy_o = (state_r == armed_s) || (state_r == run_s) || (state_r == drain_s);
        done_o = (state_r == done_s);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cfg_err_o    <= 1'b0;
            acc_enable_o <= 1'b0;
            acc_clear_o  <= 1'b0;
            acc_addr_o   <= '0;
            acc_data_o   <= '0;
            pass_cnt_o   <= '0;
            trig_miss_o  <= 1'b0;
            n_r          <= '0;
            p_r          <= '0;
            k_r          <= '0;
            drain_cnt_r  <= '0;
        end else begin
            cfg_err_o    <= cfg_v_i && cfg_open && !cfg_ok;
            acc_enable_o <= accept;
            // pass 0 overwrites stale RAM contents instead of adding to them
            acc_clear_o  <= accept && (pass_cnt_o == '0);
            if (accept) begin
                acc_addr_o <= k_r;
                acc_data_o <= data_i;
                k_r        <= k_r + 1'b1;
            end
            if ((state_r == armed_s) && trig_i) begin
                k_r <= '0;
            end
            if (cfg_load) begin
                n_r         <= cfg_samples_i;
                p_r         <= cfg_passes_i;
                pass_cnt_o  <= '0;
                trig_miss_o <= 1'b0;
            end else if (trig_late) begin
                trig_miss_o <= 1'b1;
            end
            // counts from the last-enable cycle so the final write lands before re-arming
            if (last_sample) begin
                drain_cnt_r <= '0;
            end else if (state_r == drain_s) begin
                drain_cnt_r <= drain_cnt_r + 1'b1;
            end
            if (drain_end) begin
                pass_cnt_o <= pass_next;
            end
        end
    end

endmodule
